// File: rtl/psg_write_sequencer.sv
// psg_write_sequencer
//   Buffers host command bytes for an SN76489 core and replays them on the
//   PSG data / WE_n / READY bus with programmable setup, strobe and hold.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   host_data/valid/ready byte push interface; push = host_valid & host_ready
//   flush                drops every queued byte that has not started yet
//   psg_data, psg_we_n   PSG data bus and active-low write strobe
//   psg_ready            PSG READY, low while the PSG is latching
//   busy                 registered: sequencer active or FIFO non-empty
//   timeout_err, err_clr sticky READY-timeout flag and its clear
//
// Optional build: define PSG_SEQ_SHADOW_EN to add shadow_addr / shadow_q and a
// shadow copy of the PSG register file.
module psg_write_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int MIN_STROBE    = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int READY_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
`ifdef PSG_SEQ_SHADOW_EN
  input  logic [2:0] shadow_addr,
  output logic [9:0] shadow_q,
`endif
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic       flush,
  output logic [7:0] psg_data,
  output logic       psg_we_n,
  input  logic       psg_ready,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0] SETUP_C   = 8'(SETUP_CYCLES);
  localparam logic [7:0] MIN_C     = 8'(MIN_STROBE);
  localparam logic [7:0] HOLD_C    = 8'(HOLD_CYCLES);
  localparam logic [7:0] TIMEOUT_C = 8'(READY_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt, fifo_cnt_nxt;
  state_t           state;
  logic [7:0]       cyc_cnt;
  // Set while the byte being issued is still the FIFO head; a flush clears it
  // so bytes pushed after the flush are not popped by the old write.
  logic             head_live;

  logic push, pop, fifo_empty, start;
  logic strobe_done, strobe_to, strobe_exit, hold_exit, issue_done;

  assign fifo_empty  = (fifo_cnt == '0);
  assign push        = host_valid && host_ready && !flush;
  assign start       = (state == IDLE) && !fifo_empty && !flush;
  assign strobe_done = (state == STROBE) && (cyc_cnt >= MIN_C) && psg_ready;
  assign strobe_to   = (state == STROBE) && !strobe_done && (cyc_cnt >= TIMEOUT_C);
  assign strobe_exit = strobe_done || strobe_to;
  assign hold_exit   = (state == HOLD) && (cyc_cnt == 8'd1);
  assign issue_done  = (HOLD_CYCLES == 0) ? strobe_exit : hold_exit;
  assign pop         = issue_done && head_live && !flush;

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (flush)
      fifo_cnt_nxt = '0;
    else if (push && !pop)
      fifo_cnt_nxt = fifo_cnt + 1'b1;
    else if (pop && !push)
      fifo_cnt_nxt = fifo_cnt - 1'b1;
  end

  // ---- command FIFO: pointers, occupancy, registered host_ready ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      host_ready <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_cnt   <= fifo_cnt_nxt;
      host_ready <= (fifo_cnt_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= host_data;
  end

  // ---- bus sequencer: IDLE -> SETUP -> STROBE -> HOLD ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      psg_data    <= '0;
      psg_we_n    <= 1'b1;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      head_live   <= 1'b0;
    end else begin
      busy <= (state != IDLE) || !fifo_empty;

      if (strobe_to)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;

      if (flush) head_live <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            psg_data  <= fifo_mem[rd_ptr];
            head_live <= 1'b1;
            if (SETUP_CYCLES == 0) begin
              state    <= STROBE;
              psg_we_n <= 1'b0;
              cyc_cnt  <= 8'd1;
            end else begin
              state   <= SETUP;
              cyc_cnt <= SETUP_C;
            end
          end
        end
        SETUP: begin
          if (cyc_cnt == 8'd1) begin
            state    <= STROBE;
            psg_we_n <= 1'b0;
            cyc_cnt  <= 8'd1;
          end else begin
            cyc_cnt <= cyc_cnt - 8'd1;
          end
        end
        STROBE: begin
          // cyc_cnt counts strobe cycles including the current one
          if (strobe_exit) begin
            psg_we_n <= 1'b1;
            if (HOLD_CYCLES == 0) begin
              state     <= IDLE;
              cyc_cnt   <= '0;
              head_live <= 1'b0;
            end else begin
              state   <= HOLD;
              cyc_cnt <= HOLD_C;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (hold_exit) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            head_live <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PSG_SEQ_SHADOW_EN
  // Register index r: r[0]=1 volume of channel r[2:1]; r=6 noise; else tone.
  logic [9:0] tone_r  [3];
  logic [3:0] vol_r   [4];
  logic [2:0] noise_r;
  logic [2:0] latch_reg;
  logic [2:0] wr_reg;

  assign wr_reg = psg_data[7] ? psg_data[6:4] : latch_reg;

  // ---- shadow update on each issued byte ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) tone_r[i] <= '0;
      for (int i = 0; i < 4; i++) vol_r[i] <= 4'hF;
      noise_r   <= '0;
      latch_reg <= '0;
    end else if (issue_done) begin
      if (psg_data[7]) latch_reg <= psg_data[6:4];
      if (wr_reg[0])
        vol_r[wr_reg[2:1]] <= psg_data[3:0];
      else if (wr_reg[2:1] == 2'd3)
        noise_r <= psg_data[2:0];
      else if (psg_data[7])
        tone_r[wr_reg[2:1]][3:0] <= psg_data[3:0];
      else
        tone_r[wr_reg[2:1]][9:4] <= psg_data[5:0];
    end
  end

  always_comb begin
    shadow_q = '0;
    if (shadow_addr[0])
      shadow_q = {6'd0, vol_r[shadow_addr[2:1]]};
    else if (shadow_addr[2:1] == 2'd3)
      shadow_q = {7'd0, noise_r};
    else
      shadow_q = tone_r[shadow_addr[2:1]];
  end
`endif

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Scoreboard bench for psg_write_sequencer (default parameters).
// Stimulus pushes accepted bytes into exp_q; a PSG responder picks a READY
// latency per strobe and records it in lat_q; the monitor, sampling 1 time unit
// after each rising edge, checks every strobe, the FIFO handshake, busy and
// the sticky timeout flag against a transaction-level model.
module tb_psg_write_sequencer;
  localparam int DEPTH = 4;
  localparam int SETUP = 1;
  localparam int MINS  = 2;
  localparam int HOLD  = 1;
  localparam int TO    = 64;

  logic       clk = 1'b0;
  logic       reset, host_valid, flush, psg_ready, err_clr;
  logic [7:0] host_data, psg_data;
  logic       host_ready, psg_we_n, busy, timeout_err;
`ifdef PSG_SEQ_SHADOW_EN
  logic [2:0] shadow_addr = 3'd0;
  logic [9:0] shadow_q;
`endif

  always #5 clk = ~clk;

  psg_write_sequencer dut (
    .clk         (clk),
    .reset       (reset),
`ifdef PSG_SEQ_SHADOW_EN
    .shadow_addr (shadow_addr),
    .shadow_q    (shadow_q),
`endif
    .host_data   (host_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .flush       (flush),
    .psg_data    (psg_data),
    .psg_we_n    (psg_we_n),
    .psg_ready   (psg_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];   // bytes accepted and not yet seen completing on the bus
  int         lat_q[$];   // READY latency chosen for each strobe
  bit         ghost;      // exp_q front is in flight but already flushed from the FIFO
  int         lat_mode, lat_fixed;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- PSG READY responder ----------------
  int rk, rlat;
  initial begin
    psg_ready = 1'b1;
    rk = 0;
    rlat = 0;
    forever begin
      @(negedge clk);
      if (reset || psg_we_n) begin
        rk = 0;
        psg_ready = 1'b1;
      end else begin
        if (rk == 0) begin
          if (lat_mode == 0) rlat = lat_fixed;
          else rlat = ($urandom_range(0, 15) == 0) ? 70 : int'($urandom_range(0, 10));
          lat_q.push_back(rlat);
        end
        rk++;
        psg_ready = (rk > rlat);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit         m_prev_we, m_hold_counts, m_prev_work, m_err, m_rise, m_fall, m_to;
  logic [7:0] m_prev_data;
  int         m_stable, m_low, m_hold_left, m_lat, m_len, m_occ;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("rst_we_n", int'(psg_we_n), 1);
        chk("rst_psg_data", int'(psg_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_host_ready", int'(host_ready), 1);
        exp_q.delete();
        lat_q.delete();
        ghost = 1'b0;
        m_prev_we = 1'b1; m_prev_data = 8'd0; m_stable = 0; m_low = 0;
        m_hold_left = 0; m_hold_counts = 1'b0; m_prev_work = 1'b0; m_err = 1'b0;
      end else begin
        m_to = 1'b0;
        if (m_hold_left > 0) m_hold_left--;
        m_rise = (m_prev_we == 1'b0) && (psg_we_n == 1'b1);
        m_fall = (m_prev_we == 1'b1) && (psg_we_n == 1'b0);
        if (psg_data != m_prev_data) m_stable = 0;
        else if (m_stable < 1000) m_stable++;

        if (m_fall) begin
          m_low = 0;
          if (exp_q.size() == 0) chk("unexpected_write", int'(psg_data), -1);
          else begin
            chk("strobe_data", int'(psg_data), int'(exp_q[0]));
            chk("setup_time", int'(m_stable >= SETUP), 1);
          end
        end
        if (psg_we_n == 1'b0) begin
          m_low++;
          if (!m_fall && exp_q.size() > 0) chk("data_during_strobe", int'(psg_data), int'(exp_q[0]));
        end
        if (m_rise) begin
          if (lat_q.size() == 0) chk("strobe_without_latency", m_low, -1);
          else begin
            m_lat = lat_q.pop_front();
            m_len = (m_lat + 1 > MINS) ? m_lat + 1 : MINS;
            m_to  = (m_len > TO);
            if (m_to) m_len = TO;
            chk("strobe_len", m_low, m_len);
          end
          if (exp_q.size() > 0) begin
            chk("hold_data", int'(psg_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
          end
          m_hold_counts = !ghost;
          ghost = 1'b0;
          m_hold_left = HOLD;
        end

        if (m_to) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        chk("timeout_err", int'(timeout_err), int'(m_err));

        m_occ = exp_q.size() - int'(ghost) + ((m_hold_left > 0 && m_hold_counts) ? 1 : 0);
        chk("host_ready", int'(host_ready), int'(m_occ < DEPTH));

        chk("busy", int'(busy), int'(m_prev_work));
        m_prev_work = (exp_q.size() > 0) || (m_hold_left > 0);
        m_prev_we   = psg_we_n;
        m_prev_data = psg_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    int w;
    host_data  = b;
    host_valid = 1'b1;
    w = 0;
    while (!host_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!host_ready) begin
      chk("host_ready_wait", 0, 1);
      host_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(negedge clk);
      host_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy || !psg_we_n) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_we_low();
    int w;
    w = 0;
    while (psg_we_n && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (psg_we_n) chk("wait_strobe", int'(psg_we_n), 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    if (exp_q.size() > 0) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      ghost = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  int r;
  initial begin
    reset = 1'b1; host_valid = 1'b0; host_data = 8'd0; flush = 1'b0; err_clr = 1'b0;
    lat_mode = 0; lat_fixed = 0; ghost = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single write, immediate READY
    lat_fixed = 0;
    send(8'h9F);
    wait_idle();

    // burst of five into a four-deep FIFO, READY low 32 cycles per strobe
    lat_fixed = 32;
    send(8'h80); send(8'h05); send(8'hBF); send(8'hDF); send(8'hFF);
    wait_idle();

    // slow READY
    send(8'hC3);
    wait_idle();

    // READY stuck low: timeout, flag holds until err_clr
    lat_fixed = 200;
    send(8'h90);
    wait_idle();
    repeat (5) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (3) @(negedge clk);

    // timeout while err_clr is held: the set wins, then clears
    err_clr = 1'b1;
    send(8'hA1);
    wait_idle();
    err_clr = 1'b0;

    // flush mid-strobe with three queued
    lat_fixed = 20;
    send(8'h81); send(8'h12); send(8'h23); send(8'h34);
    wait_we_low();
    repeat (3) @(negedge clk);
    do_flush();
    wait_idle();

    // reset mid-write loses the queue
    lat_fixed = 30;
    send(8'h11); send(8'h22);
    wait_we_low();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lat_fixed = 0;
    send(8'h33);
    wait_idle();

    // randomized traffic
    lat_mode = 1;
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0 && psg_we_n == 1'b0) do_flush();
      else if (r == 1) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
      end else begin
        send(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psg_write_sequencer.md
Name: psg_write_sequencer

Overview:
- Host-side controller that buffers byte commands for the SN76489 PSG core and issues them on the PSG's 8-bit data / WE_n / READY bus with guaranteed setup, strobe and hold timing.
- Sits between the tile input pins (or an SPI/parallel front-end) and the sn76489 core inside the top-level wrapper.
- Serialises back-to-back host writes so none are lost while the PSG is busy latching.

Parameters:
- FIFO_DEPTH, 4, command buffer entries; power of 2, minimum 2.
- SETUP_CYCLES, 1, cycles psg_data is stable before psg_we_n falls; range 0..15.
- MIN_STROBE, 2, minimum cycles psg_we_n is held low before psg_ready is honoured; range 1..15.
- HOLD_CYCLES, 1, cycles psg_data is held after psg_we_n rises; range 0..15.
- READY_TIMEOUT, 64, maximum strobe cycles before a forced release; range 8..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- host_data  in  8  SN76489 command byte (latch byte if bit7=1, data byte if bit7=0)
- host_valid  in  1  host offers host_data
- host_ready  out  1  FIFO can accept; push = host_valid & host_ready
- flush  in  1  discard all queued, not-yet-started commands
- psg_data  out  8  byte driven to the PSG data bus
- psg_we_n  out  1  active-low write strobe to the PSG
- psg_ready  in  1  PSG READY; low while the internal write is in progress
- busy  out  1  FSM not IDLE, or FIFO not empty
- timeout_err  out  1  sticky; set when READY_TIMEOUT expires
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset values: psg_we_n=1, psg_data=0, busy=0, timeout_err=0, host_ready=1, FIFO empty, FSM=IDLE, all counters 0.
- Reset mid-write: psg_we_n returns high on the first clock edge with reset=1, and queued bytes are lost.
- FIFO:
  - host_ready = !full, registered from occupancy.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Simultaneous push and pop while not full: occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH) wide, with a separate count register (0..FIFO_DEPTH).
- FSM states and transitions:
  - IDLE: if FIFO is not empty, load psg_data from the FIFO head and enter SETUP with the counter set to SETUP_CYCLES. If SETUP_CYCLES=0, go straight to STROBE.
  - SETUP: decrement the counter; when it reaches 0, go to STROBE and set psg_we_n=0.
  - STROBE:
    - psg_we_n=0 for at least MIN_STROBE cycles.
    - Afterwards, the first cycle with psg_ready=1 goes to HOLD.
    - If the strobe length reaches READY_TIMEOUT, set timeout_err and go to HOLD.
  - HOLD: psg_we_n=1 and psg_data unchanged. Count HOLD_CYCLES, then pop the FIFO and return to IDLE.
  - The pop occurs in the HOLD exit cycle (or the STROBE exit cycle when HOLD_CYCLES=0).
- Throughput: with defaults and immediate READY, the minimum write period is 1 (IDLE) + 1 + 2 + 1 = 5 cycles per byte.
- psg_data changes only on the IDLE→SETUP or IDLE→STROBE transition. It is never altered while psg_we_n=0 or during HOLD.
- flush:
  - Empties the FIFO in the same cycle; a push in the same cycle is dropped.
  - An in-flight write (SETUP/STROBE/HOLD) completes normally, and its pop is suppressed because the FIFO is already empty.
- err_clr has priority below a same-cycle timeout set: the set wins.
- busy is registered and goes to 0 the cycle after the FSM enters IDLE with an empty FIFO.

Optional Feature:
- Macro: PSG_SEQ_SHADOW_EN.
- When defined, adds ports shadow_addr (in, 3) and shadow_q (out, 10) plus a shadow register file mirroring the PSG registers.
  - Register map: 0/2/4 = tone 10-bit, 1/3/5/7 = volume 4-bit, 6 = noise 3-bit. Unused bits read 0.
  - Entries update when a byte is issued, in the HOLD exit cycle.
  - A latch byte stores the channel/type, writes the low 4 bits (tone low nibble, volume, or noise bits[2:0]) and remembers the register.
  - A data byte writes tone bits[9:4] of the latched register, or the low bits for volume/noise.
  - shadow_q is combinational from shadow_addr.
  - All entries reset to 0 except volumes, which reset to 4'hF (silent).
- When not defined: no shadow ports or logic; the interface is exactly as listed above.

Test Plan:
- Single write, defaults: push 8'h9F with psg_ready=1 → psg_data=9F one cycle before psg_we_n=0, psg_we_n low exactly 2 cycles, busy drops 1 cycle after return to IDLE.
- Burst: push 8'h80, 8'h05, 8'hBF, 8'hDF, 8'hFF back-to-back with FIFO_DEPTH=4 and psg_ready held low 32 cycles per strobe → host_ready low after 4 accepted, 5th accepted after first pop, all 5 bytes appear in order.
- Slow READY: psg_ready drops 1 cycle after WE falls and rises 32 cycles later → psg_we_n low for 33 cycles, no timeout_err.
- Timeout: psg_ready stuck 0 → psg_we_n rises after 64 low cycles, timeout_err=1 and stays set until err_clr=1.
- Flush mid-strobe with 3 queued → current byte completes, remaining 3 never driven, busy=0 after HOLD.
- Shadow (PSG_SEQ_SHADOW_EN): push 8'h8E, 8'h3F → shadow_addr=0 reads 10'h3FE; push 8'h94 → addr 1 reads 4.
